// File: rtl/vga_pkg.sv
// Shared raster timing constants and phase type for the VGA sync generator.
// Defaults describe 640x480@60 with a 10-bit counter per axis.
package vga_pkg;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef enum logic [1:0] {
    PH_VIS,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis.sv
// One raster axis: a wrapping position counter plus its VIS/FRONT/SYNC/BACK phase.
// The phase register tracks the counter so downstream logic never decodes ranges.
module vga_axis
  import vga_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output phase_e           phase,
  output logic             wrap
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

  localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(VISIBLE + FRONT + SYNC);

  // Every phase must be at least one unit long or the phase walk skips a state.
  if (VISIBLE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_phase_check
    $error("vga_axis: every phase length must be at least 1");
  end
  if (TOTAL > CNT_MAX) begin : g_total_check
    $error("vga_axis: axis total exceeds counter range");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_e           phase_q, phase_d;

  assign wrap = (cnt_q == LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (step) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      unique case (phase_q)
        PH_VIS:   if (cnt_d == FRONT_START) phase_d = PH_FRONT;
        PH_FRONT: if (cnt_d == SYNC_START)  phase_d = PH_SYNC;
        PH_SYNC:  if (cnt_d == BACK_START)  phase_d = PH_BACK;
        PH_BACK:  if (wrap)                 phase_d = PH_VIS;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= PH_VIS;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign cnt   = cnt_q;
  assign phase = phase_q;

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel-enable divider, H/V counters, and a one-pixel output
// pipeline that keeps pix, hsync and vsync aligned, plus a start-of-vblank tick.
module vga_sync
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             draw,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             pix_en,
  output logic             pix,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_tick
);

  localparam int H_TOT = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOT = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W = 4;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] V_LAST_VIS = CNT_W'(V_VISIBLE - 1);

  if (H_TOT > CNT_MAX || V_TOT > CNT_MAX) begin : g_size_check
    $error("vga_sync: H or V total does not fit the 10-bit counters");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
    $error("vga_sync: CLK_DIV must be within 1..16");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic             pix_q, pix_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_tick_q, frame_tick_d;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  phase_e           h_phase, v_phase;
  logic             h_wrap;
  logic             v_wrap_unused;
  logic             v_step;

  // pix_en is registered so it is low during reset even when CLK_DIV is 1.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d = (div_q == DIV_LAST);
  end

  assign v_step = pix_en_q && h_wrap;

  vga_axis #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (pix_en_q),
    .cnt   (h_cnt),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_axis #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .step  (v_step),
    .cnt   (v_cnt),
    .phase (v_phase),
    .wrap  (v_wrap_unused)
  );

  // Output stage samples the pre-advance position, so it lags the counters by one pixel.
  always_comb begin
    pix_d        = pix_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    frame_tick_d = v_step && (v_cnt == V_LAST_VIS);
    if (pix_en_q) begin
      pix_d   = draw && (h_phase == PH_VIS) && (v_phase == PH_VIS);
      hsync_d = (h_phase != PH_SYNC);
      vsync_d = (v_phase != PH_SYNC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      pix_en_q     <= 1'b0;
      pix_q        <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      pix_en_q     <= pix_en_d;
      pix_q        <= pix_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hcnt       = h_cnt;
  assign vcnt       = v_cnt;
  assign pix_en     = pix_en_q;
  assign pix        = pix_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync.sv
// Three vga_sync instances (two reduced timings, one full 640x480) driven with random
// draw and checked every clock against a position model derived from the clock count.
module tb_vga_sync;

  localparam int N = 3;

  localparam int P_D  [N] = '{2, 1, 1};
  localparam int P_HV [N] = '{16, 10, 640};
  localparam int P_HF [N] = '{2, 2, 16};
  localparam int P_HS [N] = '{3, 3, 96};
  localparam int P_HB [N] = '{3, 4, 48};
  localparam int P_VV [N] = '{10, 6, 480};
  localparam int P_VF [N] = '{2, 1, 10};
  localparam int P_VS [N] = '{2, 2, 2};
  localparam int P_VB [N] = '{3, 2, 33};

  logic       clk = 1'b0;
  logic       rst;
  logic       draw;
  logic [9:0] hcnt [N];
  logic [9:0] vcnt [N];
  logic       pix_en [N];
  logic       pix [N];
  logic       hsync [N];
  logic       vsync [N];
  logic       frame_tick [N];

  int n_checks = 0;
  int n_fail   = 0;

  // Edges seen since reset release, and the pixel value each model expects.
  int k = 0;
  bit exp_pix [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    vga_sync #(
      .CLK_DIV   (P_D[g]),
      .H_VISIBLE (P_HV[g]),
      .H_FRONT   (P_HF[g]),
      .H_SYNC    (P_HS[g]),
      .H_BACK    (P_HB[g]),
      .V_VISIBLE (P_VV[g]),
      .V_FRONT   (P_VF[g]),
      .V_SYNC    (P_VS[g]),
      .V_BACK    (P_VB[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .draw       (draw),
      .hcnt       (hcnt[g]),
      .vcnt       (vcnt[g]),
      .pix_en     (pix_en[g]),
      .pix        (pix[g]),
      .hsync      (hsync[g]),
      .vsync      (vsync[g]),
      .frame_tick (frame_tick[g])
    );
  end

  always #5 clk = ~clk;

  function automatic int ht(input int d);
    return P_HV[d] + P_HF[d] + P_HS[d] + P_HB[d];
  endfunction

  function automatic int vt(input int d);
    return P_VV[d] + P_VF[d] + P_VS[d] + P_VB[d];
  endfunction

  // Pixel periods completed after kk clock edges out of reset (kk >= 1).
  function automatic int pixels(input int d, input int kk);
    return (kk - 1) / P_D[d];
  endfunction

  // True when the counters moved on edge kk.
  function automatic bit advanced_at(input int d, input int kk);
    return (kk >= 2) && ((kk - 1) % P_D[d] == 0);
  endfunction

  function automatic bit visible_at(input int d, input int q);
    return ((q % ht(d)) < P_HV[d]) && ((q / ht(d)) < P_VV[d]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      for (int d = 0; d < N; d++) exp_pix[d] = 1'b0;
    end else begin
      k = k + 1;
      for (int d = 0; d < N; d++) begin
        if (advanced_at(d, k))
          exp_pix[d] = draw && visible_at(d, pixels(d, k - 1) % (ht(d) * vt(d)));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input int eh, input int ev, input bit epe,
                           input bit ep, input bit ehs, input bit evs, input bit eft);
    check($sformatf("u%0d.hcnt", d),       32'(hcnt[d]),       32'(eh));
    check($sformatf("u%0d.vcnt", d),       32'(vcnt[d]),       32'(ev));
    check($sformatf("u%0d.pix_en", d),     32'(pix_en[d]),     32'(epe));
    check($sformatf("u%0d.pix", d),        32'(pix[d]),        32'(ep));
    check($sformatf("u%0d.hsync", d),      32'(hsync[d]),      32'(ehs));
    check($sformatf("u%0d.vsync", d),      32'(vsync[d]),      32'(evs));
    check($sformatf("u%0d.frame_tick", d), 32'(frame_tick[d]), 32'(eft));
  endtask

  task automatic compare_all();
    for (int d = 0; d < N; d++) begin
      if (rst || k == 0) begin
        check_dut(d, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end else begin
        int  pa    = pixels(d, k);
        int  p     = pa % (ht(d) * vt(d));
        int  q;
        int  hs_lo = P_HV[d] + P_HF[d];
        int  vs_lo = P_VV[d] + P_VF[d];
        bit  ehs   = 1'b1;
        bit  evs   = 1'b1;
        bit  eft   = advanced_at(d, k) && (p == ht(d) * P_VV[d]);
        if (pa >= 1) begin
          q   = (pa - 1) % (ht(d) * vt(d));
          ehs = !(((q % ht(d)) >= hs_lo) && ((q % ht(d)) < hs_lo + P_HS[d]));
          evs = !(((q / ht(d)) >= vs_lo) && ((q / ht(d)) < vs_lo + P_VS[d]));
        end
        check_dut(d, p % ht(d), p / ht(d), (k % P_D[d]) == 0, exp_pix[d], ehs, evs, eft);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
      draw = 1'($urandom);
    end
  endtask

  initial begin
    rst  = 1'b0;
    draw = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    run(2600);

    // Asynchronous reset between edges must clear outputs before the next edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 for (int d = 0; d < N; d++) check_dut(d, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run(3);
    @(posedge clk);
    #2 rst = 1'b0;
    run(1200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
